mbist_march_ctrl: RTL and testbench

- Memory BIST controller that runs a March C- algorithm over the 256x8 synchronous test memory.
- Drives the memory's write_en/read_en/addr/write_data directly and compares returned read_data.
- Reports pass/fail to the JTAG-side BIST register; started and aborted by single-cycle pulses from the TAP instruction decoder.

---
 rtl/mbist_march_ctrl_if.sv | 28 ++
 rtl/mbist_march_ctrl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mbist_march_ctrl_if.sv
// rtl/mbist_march_ctrl_if.sv - memory-side bus between the March C- BIST controller and the test memory
interface mbist_march_ctrl_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              mem_write_en;
   logic              mem_read_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_write_data;
   logic [DATA_W-1:0] mem_read_data;

   // controller side drives the command, memory returns read data one cycle later
   modport master (
      output mem_write_en,
      output mem_read_en,
      output mem_addr,
      output mem_write_data,
      input  mem_read_data
   );

   modport slave (
      input  mem_write_en,
      input  mem_read_en,
      input  mem_addr,
      input  mem_write_data,
      output mem_read_data
   );
endinterface

// File: rtl/mbist_march_ctrl.sv
// rtl/mbist_march_ctrl.sv - March C- memory BIST controller; define MBIST_DIAG_EN to build first-fail diagnostics
module mbist_march_ctrl #(
   parameter int                ADDR_W     = 8,
   parameter int                DATA_W     = 8,
   parameter logic [DATA_W-1:0] BG_PATTERN = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic                abort_i,
   mbist_march_ctrl_if.master  mem,
   output logic                busy_o,
   output logic                done_o,
   output logic                fail_o,
   output logic [ADDR_W-1:0]   fail_addr_o,
   output logic [2:0]          fail_elem_o,
   output logic [DATA_W-1:0]   fail_exp_o,
   output logic [DATA_W-1:0]   fail_act_o,
   output logic [15:0]         fail_count_o
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FLUSH,
      ST_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [2:0]        ELEM_LAST = 3'd5;

   state_t            state_q;

   // sequence pointer: the next op to issue (element, address, op slot within the address)
   logic [2:0]        elem_q;
   logic [ADDR_W-1:0] addr_q;
   logic              phase_q;
   logic              seq_end_q;

   // registered memory command
   logic              mem_write_en_q;
   logic              mem_read_en_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_write_data_q;
   logic [DATA_W-1:0] op_exp_q;

   // compare stage: expected data for the read issued last cycle
   logic              cmp_valid_q;
   logic [DATA_W-1:0] cmp_exp_q;

   logic              busy_q;
   logic              done_q;
   logic              fail_q;

   logic              start_accept;
   logic              issue;
   logic              miscmp;
   logic [2:0]        cur_elem;
   logic [ADDR_W-1:0] cur_addr;
   logic              cur_phase;
   logic              cur_down;
   logic              cur_write;
   logic              cur_one;
   logic [DATA_W-1:0] cur_data;
   logic              cur_last_phase;
   logic              cur_last_addr;
   logic              cur_final;
   logic [2:0]        elem_d;
   logic [ADDR_W-1:0] addr_d;
   logic              phase_d;

   // decode the op at the sequence pointer and compute where the pointer goes next
   always_comb begin
      start_accept = start_i && !abort_i && (state_q == ST_IDLE || state_q == ST_DONE);
      issue        = start_accept || (state_q == ST_RUN && !seq_end_q && !abort_i);

      // a start restarts the march from M0, address 0, whatever the pointer holds
      cur_elem  = start_accept ? 3'd0 : elem_q;
      cur_addr  = start_accept ? '0   : addr_q;
      cur_phase = start_accept ? 1'b0 : phase_q;

      // M3 and M4 walk the address space downwards
      cur_down  = (cur_elem == 3'd3) || (cur_elem == 3'd4);
      // M0 is write-only; in M1..M4 the second op is the write; M5 is read-only
      cur_write = (cur_elem == 3'd0) || cur_phase;
      // M1/M3 read 0 then write 1; M2/M4 read 1 then write 0; M0 writes 0, M5 reads 0
      if ((cur_elem == 3'd1) || (cur_elem == 3'd3)) begin
         cur_one = cur_phase;
      end else if ((cur_elem == 3'd2) || (cur_elem == 3'd4)) begin
         cur_one = !cur_phase;
      end else begin
         cur_one = 1'b0;
      end
      cur_data = cur_one ? ~BG_PATTERN : BG_PATTERN;

      cur_last_phase = (cur_elem == 3'd0) || (cur_elem == ELEM_LAST) || cur_phase;
      cur_last_addr  = cur_down ? (cur_addr == '0) : (cur_addr == ADDR_MAX);
      cur_final      = cur_last_phase && cur_last_addr && (cur_elem == ELEM_LAST);

      elem_d  = cur_elem;
      addr_d  = cur_addr;
      phase_d = 1'b0;
      if (!cur_last_phase) begin
         phase_d = 1'b1;
      end else if (cur_last_addr) begin
         elem_d = cur_elem + 3'd1;
         addr_d = ((elem_d == 3'd3) || (elem_d == 3'd4)) ? ADDR_MAX : '0;
      end else begin
         addr_d = cur_down ? (cur_addr - ADDR_ONE) : (cur_addr + ADDR_ONE);
      end

      miscmp = cmp_valid_q && (mem.mem_read_data != cmp_exp_q);
   end

   // control FSM: sequences the march, registers the memory command and the pass/fail status
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= ST_IDLE;
         elem_q           <= 3'd0;
         addr_q           <= '0;
         phase_q          <= 1'b0;
         seq_end_q        <= 1'b0;
         mem_write_en_q   <= 1'b0;
         mem_read_en_q    <= 1'b0;
         mem_addr_q       <= '0;
         mem_write_data_q <= '0;
         op_exp_q         <= '0;
         cmp_valid_q      <= 1'b0;
         cmp_exp_q        <= '0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         fail_q           <= 1'b0;
      end else begin
         // no op unless one is issued below; address and data park at zero
         mem_write_en_q   <= 1'b0;
         mem_read_en_q    <= 1'b0;
         mem_addr_q       <= '0;
         mem_write_data_q <= '0;

         // the read on the bus this cycle is compared next cycle
         cmp_valid_q <= mem_read_en_q && !abort_i;
         cmp_exp_q   <= op_exp_q;

         if (issue) begin
            mem_write_en_q   <= cur_write;
            mem_read_en_q    <= !cur_write;
            mem_addr_q       <= cur_addr;
            mem_write_data_q <= cur_write ? cur_data : '0;
            op_exp_q         <= cur_data;
            elem_q           <= elem_d;
            addr_q           <= addr_d;
            phase_q          <= phase_d;
            seq_end_q        <= cur_final;
         end

         if (miscmp) begin
            fail_q <= 1'b1;
         end

         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start_accept) begin
                  state_q <= ST_RUN;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  fail_q  <= 1'b0;
               end
            end
            ST_RUN: begin
               if (abort_i) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else if (seq_end_q) begin
                  // last read is on the bus; one more cycle to compare it
                  state_q <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               if (!abort_i) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign mem.mem_write_en   = mem_write_en_q;
   assign mem.mem_read_en    = mem_read_en_q;
   assign mem.mem_addr       = mem_addr_q;
   assign mem.mem_write_data = mem_write_data_q;

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign fail_o = fail_q;

`ifdef MBIST_DIAG_EN
   logic [2:0]        op_elem_q;
   logic [2:0]        cmp_elem_q;
   logic [ADDR_W-1:0] cmp_addr_q;
   logic [ADDR_W-1:0] fail_addr_q;
   logic [2:0]        fail_elem_q;
   logic [DATA_W-1:0] fail_exp_q;
   logic [DATA_W-1:0] fail_act_q;
   logic [15:0]       fail_count_q;

   // diagnostics: tag each read with its address/element and latch the first miscompare
   always_ff @(posedge clk) begin
      if (rst) begin
         op_elem_q    <= 3'd0;
         cmp_elem_q   <= 3'd0;
         cmp_addr_q   <= '0;
         fail_addr_q  <= '0;
         fail_elem_q  <= 3'd0;
         fail_exp_q   <= '0;
         fail_act_q   <= '0;
         fail_count_q <= 16'd0;
      end else begin
         op_elem_q  <= issue ? cur_elem : 3'd0;
         cmp_elem_q <= op_elem_q;
         cmp_addr_q <= mem_addr_q;
         if (start_accept) begin
            fail_addr_q  <= '0;
            fail_elem_q  <= 3'd0;
            fail_exp_q   <= '0;
            fail_act_q   <= '0;
            fail_count_q <= 16'd0;
         end else if (miscmp) begin
            // fail_q still low means this is the first miscompare of the run
            if (!fail_q) begin
               fail_addr_q <= cmp_addr_q;
               fail_elem_q <= cmp_elem_q;
               fail_exp_q  <= cmp_exp_q;
               fail_act_q  <= mem.mem_read_data;
            end
            if (fail_count_q != 16'hFFFF) begin
               fail_count_q <= fail_count_q + 16'd1;
            end
         end
      end
   end

   assign fail_addr_o  = fail_addr_q;
   assign fail_elem_o  = fail_elem_q;
   assign fail_exp_o   = fail_exp_q;
   assign fail_act_o   = fail_act_q;
   assign fail_count_o = fail_count_q;
`else
   assign fail_addr_o  = '0;
   assign fail_elem_o  = 3'd0;
   assign fail_exp_o   = '0;
   assign fail_act_o   = '0;
   assign fail_count_o = 16'd0;
`endif

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb/tb_mbist_march_ctrl.sv - self-checking bench for the March C- BIST controller
module tb_mbist_march_ctrl;

   localparam int N = 256;
`ifdef MBIST_DIAG_EN
   localparam bit DIAG_ON = 1'b1;
`else
   localparam bit DIAG_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] start;
   logic       abort;
   logic [1:0] busy, done, fail;
   logic [7:0]  fail_addr  [2];
   logic [2:0]  fail_elem  [2];
   logic [7:0]  fail_exp   [2];
   logic [7:0]  fail_act   [2];
   logic [15:0] fail_count [2];

   always #5 clk = ~clk;

   mbist_march_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus_a ();
   mbist_march_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus_b ();

   mbist_march_ctrl #(.ADDR_W(8), .DATA_W(8), .BG_PATTERN(8'h00)) dut_a (
      .clk(clk), .rst(rst), .start_i(start[0]), .abort_i(abort), .mem(bus_a),
      .busy_o(busy[0]), .done_o(done[0]), .fail_o(fail[0]),
      .fail_addr_o(fail_addr[0]), .fail_elem_o(fail_elem[0]), .fail_exp_o(fail_exp[0]),
      .fail_act_o(fail_act[0]), .fail_count_o(fail_count[0])
   );

   mbist_march_ctrl #(.ADDR_W(8), .DATA_W(8), .BG_PATTERN(8'h55)) dut_b (
      .clk(clk), .rst(rst), .start_i(start[1]), .abort_i(abort), .mem(bus_b),
      .busy_o(busy[1]), .done_o(done[1]), .fail_o(fail[1]),
      .fail_addr_o(fail_addr[1]), .fail_elem_o(fail_elem[1]), .fail_exp_o(fail_exp[1]),
      .fail_act_o(fail_act[1]), .fail_count_o(fail_count[1])
   );

   // memories with stuck-at faults applied on the read path
   logic [7:0] mem_a [N];
   logic [7:0] mem_b [N];
   logic [7:0] sa0 [N];
   logic [7:0] sa1 [N];

   always @(posedge clk) begin
      if (bus_a.mem_write_en) mem_a[bus_a.mem_addr] <= bus_a.mem_write_data;
      bus_a.mem_read_data <= bus_a.mem_read_en ?
         ((mem_a[bus_a.mem_addr] & ~sa0[bus_a.mem_addr]) | sa1[bus_a.mem_addr]) : 8'h00;
   end

   always @(posedge clk) begin
      if (bus_b.mem_write_en) mem_b[bus_b.mem_addr] <= bus_b.mem_write_data;
      bus_b.mem_read_data <= bus_b.mem_read_en ?
         ((mem_b[bus_b.mem_addr] & ~sa0[bus_b.mem_addr]) | sa1[bus_b.mem_addr]) : 8'h00;
   end

   bit         sel;
   logic       s_we, s_re;
   logic [7:0] s_addr, s_wd;

   always_comb begin
      if (sel) begin
         s_we = bus_b.mem_write_en; s_re = bus_b.mem_read_en;
         s_addr = bus_b.mem_addr;   s_wd = bus_b.mem_write_data;
      end else begin
         s_we = bus_a.mem_write_en; s_re = bus_a.mem_read_en;
         s_addr = bus_a.mem_addr;   s_wd = bus_a.mem_write_data;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // reference model: March C- written as element strings, replayed on an ideal array plus faults
   typedef struct {
      bit         wr;
      logic [7:0] addr;
      logic [7:0] data;
   } op_t;

   op_t   exp_ops[$];
   string march      [6] = '{"w0", "r0w1", "r1w0", "r0w1", "r1w0", "r0"};
   bit    march_down [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
   logic       m_fail;
   int         m_count;
   logic [7:0] m_addr, m_exp, m_act;
   logic [2:0] m_elem;

   task automatic build_model(input logic [7:0] bg);
      logic [7:0] img [N];
      exp_ops.delete();
      m_fail = 1'b0; m_count = 0; m_addr = 0; m_elem = 0; m_exp = 0; m_act = 0;
      for (int e = 0; e < 6; e++) begin
         for (int i = 0; i < N; i++) begin
            int a;
            a = march_down[e] ? (N - 1 - i) : i;
            for (int k = 0; k < march[e].len(); k += 2) begin
               logic [7:0] v;
               logic [7:0] got;
               op_t        op;
               v = (march[e].getc(k + 1) == "1") ? ~bg : bg;
               op.addr = a[7:0];
               if (march[e].getc(k) == "w") begin
                  img[a] = v; op.wr = 1'b1; op.data = v;
               end else begin
                  op.wr = 1'b0; op.data = 8'h00;
                  got = (img[a] & ~sa0[a]) | sa1[a];
                  if (got !== v) begin
                     if (!m_fail) begin
                        m_addr = a[7:0]; m_elem = e[2:0]; m_exp = v; m_act = got;
                     end
                     m_fail = 1'b1;
                     m_count++;
                  end
               end
               exp_ops.push_back(op);
            end
         end
      end
   endtask

   task automatic clear_faults();
      for (int i = 0; i < N; i++) begin
         sa0[i] = 8'h00; sa1[i] = 8'h00;
      end
   endtask

   // per-run bus observation
   int         op_idx, op_err, wr_cnt, rd_cnt, busy_cyc;
   logic       busy_at1;
   logic [7:0] m0_wd, m1_wd;

   task automatic sample_bus();
      if (s_we || s_re) begin
         if (s_we && s_re) op_err++;
         else if (op_idx >= exp_ops.size()) op_err++;
         else if (exp_ops[op_idx].wr !== s_we || exp_ops[op_idx].addr !== s_addr ||
                  (s_we && exp_ops[op_idx].data !== s_wd) || (s_re && s_wd !== 8'h00)) op_err++;
         if (s_we && op_idx == 0) m0_wd = s_wd;
         if (s_we && op_idx == N + 1) m1_wd = s_wd;
         op_idx++;
         if (s_we) wr_cnt++; else rd_cnt++;
      end else if (s_addr !== 8'h00 || s_wd !== 8'h00) begin
         op_err++;
      end
   endtask

   // caller is at a negedge in cycle 0; start is driven now and the bench tracks cycles 1, 2, ...
   task automatic run(input bit sel_i, input int abort_at, input int extra_at,
                      input int rst_at, output int end_cyc);
      int n;
      sel = sel_i;
      op_idx = 0; op_err = 0; wr_cnt = 0; rd_cnt = 0; busy_cyc = 0;
      busy_at1 = 1'b0; m0_wd = 8'h00; m1_wd = 8'h00;
      end_cyc = -1;
      start[sel] = 1'b1;
      n = 0;
      while (end_cyc < 0 && n < 2700) begin
         @(negedge clk);
         n++;
         start = 2'b00; abort = 1'b0; rst = 1'b0;
         sample_bus();
         if (n == 1) busy_at1 = busy[sel];
         if (busy[sel] === 1'b1) busy_cyc++;
         if (done[sel] === 1'b1 || n == abort_at + 1 || n == rst_at + 1) begin
            end_cyc = n;
         end else begin
            if (n == extra_at) start[sel] = 1'b1;
            if (n == abort_at) abort = 1'b1;
            if (n == rst_at)   rst = 1'b1;
         end
      end
      if (end_cyc < 0) end_cyc = n;
   endtask

   task automatic check_diag_a(input string tag);
      check({tag, "_fail"},  fail[0],       m_fail);
      check({tag, "_addr"},  fail_addr[0],  DIAG_ON ? m_addr : 8'h00);
      check({tag, "_elem"},  fail_elem[0],  DIAG_ON ? m_elem : 3'd0);
      check({tag, "_exp"},   fail_exp[0],   DIAG_ON ? m_exp : 8'h00);
      check({tag, "_act"},   fail_act[0],   DIAG_ON ? m_act : 8'h00);
      check({tag, "_count"}, fail_count[0], DIAG_ON ? m_count[15:0] : 16'd0);
   endtask

   initial begin
      int   ec;
      int   fa, fb;
      logic [7:0] fm;

      rst = 1'b1; start = 2'b00; abort = 1'b0; sel = 1'b0;
      clear_faults();
      repeat (3) @(negedge clk);

      // reset state of both controllers
      for (int d = 0; d < 2; d++) begin
         check("rst_busy", busy[d], 1'b0);
         check("rst_done", done[d], 1'b0);
         check("rst_fail", fail[d], 1'b0);
         check("rst_diag", {fail_addr[d], fail_elem[d], fail_exp[d], fail_act[d], fail_count[d]}, 32'd0);
      end
      check("rst_bus_a", {bus_a.mem_write_en, bus_a.mem_read_en, bus_a.mem_addr, bus_a.mem_write_data}, 32'd0);
      check("rst_bus_b", {bus_b.mem_write_en, bus_b.mem_read_en, bus_b.mem_addr, bus_b.mem_write_data}, 32'd0);
      rst = 1'b0;

      // fault-free run, background 00
      build_model(8'h00);
      run(1'b0, -10, -10, -10, ec);
      check("ff_done_cycle", ec, 2562);
      check("ff_ops", op_err, 0);
      check("ff_writes", wr_cnt, 1280);
      check("ff_reads", rd_cnt, 1280);
      check("ff_busy_at1", busy_at1, 1'b1);
      check("ff_busy_cycles", busy_cyc, 2561);
      check("ff_busy_end", busy[0], 1'b0);
      check("ff_fail", fail[0], 1'b0);

      // bit 3 stuck-at-0 at 0x2A
      sa0[8'h2A] = 8'h08;
      build_model(8'h00);
      run(1'b0, -10, -10, -10, ec);
      check("sa0_done_cycle", ec, 2562);
      check("sa0_ops", op_err, 0);
      check("sa0_fail", fail[0], 1'b1);
      check("sa0_addr",  fail_addr[0],  DIAG_ON ? 8'h2A : 8'h00);
      check("sa0_elem",  fail_elem[0],  DIAG_ON ? 3'd2 : 3'd0);
      check("sa0_exp",   fail_exp[0],   DIAG_ON ? 8'hFF : 8'h00);
      check("sa0_act",   fail_act[0],   DIAG_ON ? 8'hF7 : 8'h00);
      check("sa0_count", fail_count[0], DIAG_ON ? 16'd2 : 16'd0);
      repeat (5) @(negedge clk);
      check("sa0_hold_done", done[0], 1'b1);
      check("sa0_hold_fail", fail[0], 1'b1);

      // abort at 1000 after the fault has been seen: fail is kept, done stays low
      run(1'b0, 1000, -10, -10, ec);
      check("abf_cycle", ec, 1001);
      check("abf_busy", busy[0], 1'b0);
      check("abf_done", done[0], 1'b0);
      check("abf_fail", fail[0], 1'b1);
      check("abf_addr", fail_addr[0], DIAG_ON ? 8'h2A : 8'h00);
      clear_faults();

      // background 55 on the second controller
      @(negedge clk);
      build_model(8'h55);
      run(1'b1, -10, -10, -10, ec);
      check("bg55_done_cycle", ec, 2562);
      check("bg55_ops", op_err, 0);
      check("bg55_m0_data", m0_wd, 8'h55);
      check("bg55_m1_data", m1_wd, 8'hAA);
      check("bg55_fail", fail[1], 1'b0);
      check("bg55_count", fail_count[1], 16'd0);

      // abort at cycle 100, then a full rerun
      @(negedge clk);
      build_model(8'h00);
      run(1'b0, 100, -10, -10, ec);
      check("ab_cycle", ec, 101);
      check("ab_busy", busy[0], 1'b0);
      check("ab_enables", {bus_a.mem_write_en, bus_a.mem_read_en}, 2'b00);
      check("ab_done", done[0], 1'b0);
      @(negedge clk);
      run(1'b0, -10, -10, -10, ec);
      check("ab_rerun_cycle", ec, 2562);
      check("ab_rerun_ops", op_err, 0);
      check("ab_rerun_fail", fail[0], 1'b0);

      // start during a run is ignored
      @(negedge clk);
      run(1'b0, -10, 500, -10, ec);
      check("xs_done_cycle", ec, 2562);
      check("xs_ops", op_err, 0);

      // reset at 700 after a miscompare clears everything
      sa1[8'h05] = 8'h01;
      build_model(8'h00);
      @(negedge clk);
      run(1'b0, -10, -10, 700, ec);
      check("rr_cycle", ec, 701);
      check("rr_status", {busy[0], done[0], fail[0]}, 3'b000);
      check("rr_bus", {bus_a.mem_write_en, bus_a.mem_read_en, bus_a.mem_addr, bus_a.mem_write_data}, 32'd0);
      check("rr_diag", {fail_addr[0], fail_elem[0], fail_exp[0], fail_act[0], fail_count[0]}, 32'd0);

      // random stuck-at faults against the reference model
      for (int it = 0; it < 3; it++) begin
         clear_faults();
         for (int f = 0; f <= it; f++) begin
            fa = $urandom_range(0, N - 1);
            fb = $urandom_range(0, 7);
            fm = 8'h01 << fb;
            if ($urandom_range(0, 1) == 1) begin
               sa1[fa] = sa1[fa] | fm; sa0[fa] = sa0[fa] & ~fm;
            end else begin
               sa0[fa] = sa0[fa] | fm; sa1[fa] = sa1[fa] & ~fm;
            end
         end
         build_model(8'h00);
         @(negedge clk);
         run(1'b0, -10, -10, -10, ec);
         check("rnd_done_cycle", ec, 2562);
         check("rnd_ops", op_err, 0);
         check_diag_a("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
